// File: rtl/vending_pkg.sv
// Shared types and constants for the vending order path.
// Imported by the interface, the controller and the stock bank.
package vending_pkg;

    localparam int MONEY_W = 4;
    localparam int QTY_W   = 2;
    localparam int COST_W  = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DISPENSE,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MONEY = 2'b01;
    localparam logic [1:0] ERR_STOCK = 2'b10;
    localparam logic [1:0] ERR_QTY   = 2'b11;

    // Worst case 15 x 3 = 45, so six bits never overflow.
    function automatic logic [COST_W-1:0] calc_cost(
        input logic [MONEY_W-1:0] price,
        input logic [QTY_W-1:0]   num
    );
        logic [COST_W-1:0] p;
        logic [COST_W-1:0] n;
        p = {{(COST_W-MONEY_W){1'b0}}, price};
        n = {{(COST_W-QTY_W){1'b0}}, num};
        return p * n;
    endfunction

endpackage

// File: rtl/vending_if.sv
// Order handshake between the customer block and the controller.
// The product select is named type_sel because type is a reserved word.
interface vending_if;
    import vending_pkg::*;

    logic               order_valid;
    logic               order_ready;
    logic               mode;
    logic [MONEY_W-1:0] in_money;
    logic               type_sel;
    logic [QTY_W-1:0]   number;

    modport master (
        output order_valid,
        output mode,
        output in_money,
        output type_sel,
        output number,
        input  order_ready
    );

    modport slave (
        input  order_valid,
        input  mode,
        input  in_money,
        input  type_sel,
        input  number,
        output order_ready
    );

endinterface

// File: rtl/vending_controller_stock_bank.sv
// Two per-product stock counters with restock load and guarded decrement.
// Load wins over decrement; a counter at zero never wraps.
module stock_bank #(
    parameter logic [3:0] STOCK_INIT = 4'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_en,
    input  logic       dec_sel,
    input  logic       load_en,
    input  logic       load_sel,
    output logic [3:0] stock0,
    output logic [3:0] stock1
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stock0 <= STOCK_INIT;
            stock1 <= STOCK_INIT;
        end else begin
            if (load_en && !load_sel) begin
                stock0 <= STOCK_INIT;
            end else if (dec_en && !dec_sel && stock0 != 4'd0) begin
                stock0 <= stock0 - 4'd1;
            end

            if (load_en && load_sel) begin
                stock1 <= STOCK_INIT;
            end else if (dec_en && dec_sel && stock1 != 4'd0) begin
                stock1 <= stock1 - 4'd1;
            end
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Order-processing stage: validates an order, pulses one dispense per
// item, then strobes change/refund. Owns the stock bank.
module vending_controller
    import vending_pkg::*;
#(
    parameter logic [3:0] PRICE0     = 4'd3,
    parameter logic [3:0] PRICE1     = 4'd4,
    parameter logic [3:0] STOCK_INIT = 4'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    vending_if.slave   ord,
    output logic       dispense,
    output logic       disp_type,
    output logic       change_valid,
    output logic [3:0] change,
    output logic       refund,
    output logic [1:0] err,
    output logic [3:0] stock0,
    output logic [3:0] stock1
);

    state_t             state_q, state_d;
    logic               mode_q;
    logic [MONEY_W-1:0] money_q;
    logic               type_q;
    logic [QTY_W-1:0]   num_q;
    logic [QTY_W-1:0]   cnt_q, cnt_d;

    logic               disp_q, disp_d;
    logic               dtype_q, dtype_d;
    logic               cv_q, cv_d;
    logic [3:0]         change_q, change_d;
    logic               refund_q, refund_d;
    logic [1:0]         err_q, err_d;

    logic               accept;
    logic [3:0]         price;
    logic [3:0]         stock_sel;
    logic [COST_W-1:0]  cost;
    logic [COST_W-1:0]  money_w;
    logic [COST_W-1:0]  stock_w;
    logic [COST_W-1:0]  num_w;
    logic [1:0]         chk_err;
    logic               dec_en;
    logic               load_en;

    assign ord.order_ready = (state_q == S_IDLE);
    assign accept = ord.order_valid && (state_q == S_IDLE);

    assign price     = type_q ? PRICE1 : PRICE0;
    assign stock_sel = type_q ? stock1 : stock0;
    assign cost      = calc_cost(price, num_q);
    assign money_w   = {2'b00, money_q};
    assign stock_w   = {2'b00, stock_sel};
    assign num_w     = {4'b0000, num_q};

    // Purchase checks in priority order: quantity, stock, funds.
    always_comb begin
        chk_err = ERR_OK;
        if (num_q == 2'd0) begin
            chk_err = ERR_QTY;
        end else if (stock_w < num_w) begin
            chk_err = ERR_STOCK;
        end else if (money_w < cost) begin
            chk_err = ERR_MONEY;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        disp_d   = 1'b0;
        dtype_d  = dtype_q;
        cv_d     = 1'b0;
        change_d = 4'd0;
        refund_d = 1'b0;
        err_d    = err_q;
        dec_en   = 1'b0;
        load_en  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mode_q) begin
                    load_en  = 1'b1;
                    state_d  = S_DONE;
                    cv_d     = 1'b1;
                    change_d = money_q;
                    refund_d = 1'b1;
                    err_d    = ERR_OK;
                end else if (chk_err != ERR_OK) begin
                    state_d  = S_DONE;
                    cv_d     = 1'b1;
                    change_d = money_q;
                    refund_d = 1'b1;
                    err_d    = chk_err;
                end else begin
                    state_d = S_DISPENSE;
                    cnt_d   = num_q;
                    disp_d  = 1'b1;
                    dtype_d = type_q;
                    err_d   = ERR_OK;
                end
            end
            S_DISPENSE: begin
                dec_en = 1'b1;
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d  = S_DONE;
                    cv_d     = 1'b1;
                    change_d = money_q - cost[3:0];
                end else begin
                    disp_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            money_q  <= '0;
            type_q   <= 1'b0;
            num_q    <= '0;
            cnt_q    <= '0;
            disp_q   <= 1'b0;
            dtype_q  <= 1'b0;
            cv_q     <= 1'b0;
            change_q <= 4'd0;
            refund_q <= 1'b0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            dtype_q  <= dtype_d;
            cv_q     <= cv_d;
            change_q <= change_d;
            refund_q <= refund_d;
            err_q    <= err_d;
            if (accept) begin
                mode_q  <= ord.mode;
                money_q <= ord.in_money;
                type_q  <= ord.type_sel;
                num_q   <= ord.number;
            end
        end
    end

    assign dispense     = disp_q;
    assign disp_type    = dtype_q;
    assign change_valid = cv_q;
    assign change       = change_q;
    assign refund       = refund_q;
    assign err          = err_q;

    stock_bank #(
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk     (clk),
        .rst_n   (rst_n),
        .dec_en  (dec_en),
        .dec_sel (type_q),
        .load_en (load_en),
        .load_sel(type_q),
        .stock0  (stock0),
        .stock1  (stock1)
    );

endmodule
